// File: rtl/mono_data_rx_multi.sv
// Multi-chip MONOPIX hit receiver: round-robin token arbitration, freeze/read strobing,
// serial hit deserialisation with gray-decoded timestamps, and a first-word-fall-through output FIFO.
module mono_data_rx_multi #(
  parameter int ABUSWIDTH  = 16,
  parameter int IDENTIFIER = 0,
  parameter int NCHIP      = 4,
  parameter int COL_BITS   = 6,
  parameter int ROW_BITS   = 8,
  parameter int TS_BITS    = 6,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic [NCHIP-1:0]     RX_TOKEN,
  input  logic [NCHIP-1:0]     RX_DATA,
  output logic [NCHIP-1:0]     RX_FREEZE,
  output logic [NCHIP-1:0]     RX_READ,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  output logic                 LOST_ERROR
);

  localparam int DATA_BITS = COL_BITS + ROW_BITS + 2 * TS_BITS;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam logic [7:0] VERSION = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    TOKEN_WAIT,
    READ,
    SAMPLE,
    SHIFT,
    STORE
  } state_t;

  state_t state, state_next;

  logic soft_rst;
  logic conf_en, dis_gray;
  logic [NCHIP-1:0] ch_mask;
  logic [7:0] tw_len, rd_len, smp_dly, lost_cnt;
  logic [7:0] rd_mux;

  logic [7:0] cnt;
  logic phase_end;
  logic [NCHIP-1:0] req_q;
  logic [2:0] grant, last_g, arb_pick;
  logic arb_found;
  logic rx_bit;
  logic freeze_on;
  logic [NCHIP-1:0] read_next;
  logic [DATA_BITS-1:0] shreg;

  logic [TS_BITS-1:0] le_raw, te_raw;
  logic [DATA_BITS-1:0] data_word;
  logic [31:0] fifo_wdata;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic fifo_full, store, do_wr, do_rd;

  function automatic logic [7:0] eff_len(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [TS_BITS-1:0] gray2bin(input logic [TS_BITS-1:0] g);
    logic [TS_BITS-1:0] b;
    b[TS_BITS-1] = g[TS_BITS-1];
    for (int i = TS_BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // A write to address 0 restores every piece of state exactly like BUS_RST, one edge later.
  assign soft_rst = BUS_WR && (BUS_ADD == '0);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      conf_en  <= 1'b0;
      dis_gray <= 1'b0;
      ch_mask  <= '1;
      tw_len   <= 8'd2;
      rd_len   <= 8'd8;
      smp_dly  <= 8'd3;
    end else if (soft_rst) begin
      conf_en  <= 1'b0;
      dis_gray <= 1'b0;
      ch_mask  <= '1;
      tw_len   <= 8'd2;
      rd_len   <= 8'd8;
      smp_dly  <= 8'd3;
    end else if (BUS_WR) begin
      case (BUS_ADD)
        ABUSWIDTH'(1): begin
          conf_en  <= BUS_DATA_IN[0];
          dis_gray <= BUS_DATA_IN[1];
        end
        ABUSWIDTH'(2): ch_mask <= BUS_DATA_IN[NCHIP-1:0];
        ABUSWIDTH'(4): tw_len  <= BUS_DATA_IN;
        ABUSWIDTH'(5): rd_len  <= BUS_DATA_IN;
        ABUSWIDTH'(6): smp_dly <= BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'd0;
    case (BUS_ADD)
      ABUSWIDTH'(0): rd_mux = VERSION;
      ABUSWIDTH'(1): rd_mux = {6'd0, dis_gray, conf_en};
      ABUSWIDTH'(2): rd_mux = 8'(ch_mask);
      ABUSWIDTH'(3): rd_mux = lost_cnt;
      ABUSWIDTH'(4): rd_mux = tw_len;
      ABUSWIDTH'(5): rd_mux = rd_len;
      ABUSWIDTH'(6): rd_mux = smp_dly;
      ABUSWIDTH'(7): rd_mux = 8'(fifo_count);
      ABUSWIDTH'(8): rd_mux = 8'(32'(fifo_count) >> 8);
      default:       rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (soft_rst) begin
      BUS_DATA_OUT <= 8'd0;
    end else if (BUS_RD) begin
      BUS_DATA_OUT <= rd_mux;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= IDLE;
    end else if (soft_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    phase_end = 1'b0;
    case (state)
      TOKEN_WAIT: phase_end = (cnt == eff_len(tw_len) - 8'd1);
      READ:       phase_end = (cnt == eff_len(rd_len) - 8'd1);
      SAMPLE:     phase_end = (cnt == eff_len(smp_dly) - 8'd1);
      SHIFT:      phase_end = (cnt == 8'(DATA_BITS - 1));
      default:    phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (conf_en && ((RX_TOKEN & ch_mask) != '0)) state_next = ARB;
      ARB:        state_next = TOKEN_WAIT;
      TOKEN_WAIT: if (phase_end) state_next = READ;
      READ:       if (phase_end) state_next = SAMPLE;
      SAMPLE:     if (phase_end) state_next = SHIFT;
      SHIFT:      if (phase_end) state_next = STORE;
      STORE:      state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Round-robin search starts one past the last served channel and wraps modulo NCHIP.
  always_comb begin
    arb_pick  = last_g;
    arb_found = 1'b0;
    for (int i = 1; i <= NCHIP; i++) begin
      for (int j = 0; j < NCHIP; j++) begin
        if (!arb_found && req_q[j] && (j == (int'(last_g) + i) % NCHIP)) begin
          arb_pick  = 3'(j);
          arb_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rx_bit    = 1'b0;
    read_next = '0;
    for (int i = 0; i < NCHIP; i++) begin
      if (grant == 3'(i)) begin
        rx_bit       = RX_DATA[i];
        read_next[i] = (state == READ);
      end
    end
  end

  assign freeze_on = (state == TOKEN_WAIT) || (state == READ) ||
                     (state == SAMPLE) || (state == SHIFT);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      cnt    <= 8'd0;
      req_q  <= '0;
      grant  <= 3'd0;
      last_g <= 3'(NCHIP - 1);
      shreg  <= '0;
    end else if (soft_rst) begin
      cnt    <= 8'd0;
      req_q  <= '0;
      grant  <= 3'd0;
      last_g <= 3'(NCHIP - 1);
      shreg  <= '0;
    end else begin
      cnt <= (state_next != state) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE) req_q <= RX_TOKEN & ch_mask;
      if (state == ARB) begin
        grant  <= arb_pick;
        last_g <= arb_pick;
      end
      if (state == SHIFT) shreg <= {shreg[DATA_BITS-2:0], rx_bit};
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      RX_FREEZE <= '0;
      RX_READ   <= '0;
    end else if (soft_rst) begin
      RX_FREEZE <= '0;
      RX_READ   <= '0;
    end else begin
      RX_FREEZE <= freeze_on ? '1 : '0;
      RX_READ   <= read_next;
    end
  end

  assign le_raw    = shreg[DATA_BITS-1 -: TS_BITS];
  assign te_raw    = shreg[DATA_BITS-1-TS_BITS -: TS_BITS];
  assign data_word = dis_gray ? shreg
                              : {gray2bin(le_raw), gray2bin(te_raw), shreg[ROW_BITS+COL_BITS-1:0]};
  assign fifo_wdata = {2'(IDENTIFIER), grant, 27'(data_word)};

  assign FIFO_EMPTY = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign store      = (state == STORE);
  assign do_wr      = store && !fifo_full;
  assign do_rd      = FIFO_READ && !FIFO_EMPTY;
  assign FIFO_DATA  = mem[rd_ptr];
  assign LOST_ERROR = (lost_cnt != 8'd0);

  always_ff @(posedge BUS_CLK) begin
    if (do_wr) mem[wr_ptr] <= fifo_wdata;
  end

  // Fullness is judged before any same-cycle pop, so a STORE into a full FIFO is always lost.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lost_cnt   <= 8'd0;
    end else if (soft_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lost_cnt   <= 8'd0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (store && fifo_full && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mono_data_rx_multi.sv
// Directed bench for mono_data_rx_multi: a behavioural chip model serialises one hit per READ,
// and each step compares strobes, FIFO words and registers against hand-derived values.
module tb_mono_data_rx_multi;

  localparam int NCHIP = 4;
  localparam int DB    = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_add;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_wr, bus_rd;
  logic [NCHIP-1:0] rx_token, rx_data, rx_freeze, rx_read;
  logic        fifo_read, fifo_empty, lost_error;
  logic [31:0] fifo_data;

  logic [DB-1:0] pat [NCHIP];
  int smp_eff;
  int checks = 0;
  int failures = 0;

  mono_data_rx_multi #(
    .ABUSWIDTH(16), .IDENTIFIER(1), .NCHIP(NCHIP),
    .COL_BITS(6), .ROW_BITS(8), .TS_BITS(6), .FIFO_DEPTH(4)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_data_in),
    .BUS_DATA_OUT(bus_data_out), .BUS_WR(bus_wr), .BUS_RD(bus_rd),
    .RX_TOKEN(rx_token), .RX_DATA(rx_data), .RX_FREEZE(rx_freeze), .RX_READ(rx_read),
    .FIFO_READ(fifo_read), .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data),
    .LOST_ERROR(lost_error)
  );

  always #5 clk = ~clk;

  // Chip model: after its read strobe falls, a chip waits SMP_DLY-1 cycles then shifts its pattern out MSB first.
  initial begin
    int bitpos [NCHIP];
    logic [NCHIP-1:0] prev_read;
    rx_data   = '0;
    prev_read = '0;
    for (int i = 0; i < NCHIP; i++) bitpos[i] = 1000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCHIP; i++) begin
        if (prev_read[i] && !rx_read[i]) bitpos[i] = 1 - smp_eff;
        else if (bitpos[i] < 1000) bitpos[i]++;
        if (bitpos[i] >= 0 && bitpos[i] < DB) rx_data[i] = pat[i][DB-1-bitpos[i]];
        else rx_data[i] = 1'b0;
        prev_read[i] = rx_read[i];
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NCHIP-1:0] tok);
    @(negedge clk);
    rx_token = tok;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_add = a; bus_data_in = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_add = a; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_data_out;
  endtask

  task automatic pop();
    @(negedge clk);
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
  endtask

  task automatic wait_word(input string tag, input int budget);
    int n = 0;
    while (fifo_empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(fifo_empty), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (!fifo_empty && n < 10) begin
      pop();
      n++;
    end
  endtask

  function automatic logic [31:0] pack(input logic [2:0] ch, input logic [5:0] le, input logic [5:0] te,
                                       input logic [7:0] row, input logic [5:0] col);
    return {2'b01, ch, 1'b0, le, te, row, col};
  endfunction

  initial begin
    logic [7:0] rd;
    logic [7:0] rst_exp [9];
    logic [2:0] rr_exp [4];
    logic [2:0] ch, prev_ch;
    int first_read, read_len, first_frz;

    rst = 1'b1; bus_add = '0; bus_data_in = '0; bus_wr = 1'b0; bus_rd = 1'b0;
    rx_token = '0; fifo_read = 1'b0; smp_eff = 3;
    for (int i = 0; i < NCHIP; i++) pat[i] = '0;
    rst_exp = '{8'd2, 8'd0, 8'h0F, 8'd0, 8'd2, 8'd8, 8'd3, 8'd0, 8'd0};
    rr_exp  = '{3'd0, 3'd2, 3'd3, 3'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_freeze", 32'(rx_freeze), 32'd0);
    checkOutput("rst_read", 32'(rx_read), 32'd0);
    checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
    checkOutput("rst_lost_error", 32'(lost_error), 32'd0);
    checkOutput("rst_bus_out", 32'(bus_data_out), 32'd0);
    for (int a = 0; a < 9; a++) begin
      bus_read(16'(a), rd);
      checkOutput($sformatf("rst_reg%0d", a), 32'(rd), 32'(rst_exp[a]));
    end

    // Single hit on chip 1 with default phase lengths; token seen at cycle t = k0.
    $display("[TB] single hit");
    pat[1] = {6'b100000, 6'b000001, 8'hA5, 6'h2A};
    bus_write(16'd1, 8'd1);
    applyStimulus(4'b0010);
    first_read = -1; read_len = 0; first_frz = -1;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 2) rx_token = '0;
      if (rx_read[1]) begin
        if (first_read < 0) first_read = k;
        read_len++;
      end
      if (rx_freeze == 4'hF && first_frz < 0) first_frz = k;
      if (k == 41) checkOutput("hit_empty_at_store", 32'(fifo_empty), 32'd1);
      if (k == 42) checkOutput("hit_visible", 32'(fifo_empty), 32'd0);
    end
    checkOutput("hit_freeze_start", 32'(first_frz), 32'd3);
    checkOutput("hit_read_start", 32'(first_read), 32'd5);
    checkOutput("hit_read_len", 32'(read_len), 32'd8);
    checkOutput("hit_word", fifo_data, 32'h4BF0696A);
    pop();
    checkOutput("hit_empty_after_pop", 32'(fifo_empty), 32'd1);

    // Soft reset restores registers and restarts arbitration at channel 0.
    $display("[TB] soft reset and round robin");
    bus_write(16'd4, 8'd5);
    bus_write(16'd0, 8'd0);
    bus_read(16'd4, rd);
    checkOutput("soft_tw_len", 32'(rd), 32'd2);
    bus_read(16'd1, rd);
    checkOutput("soft_conf", 32'(rd), 32'd0);
    bus_write(16'd1, 8'd1);
    for (int i = 0; i < NCHIP; i++) pat[i] = {12'd0, 8'(i), 6'h11};
    applyStimulus(4'b1101);
    for (int n = 0; n < 4; n++) begin
      wait_word("rr", 200);
      checkOutput($sformatf("rr_ch%0d", n), 32'(fifo_data[29:27]), 32'(rr_exp[n]));
      if (n == 0) checkOutput("rr_word0", fifo_data, pack(3'd0, 6'd0, 6'd0, 8'd0, 6'h11));
      pop();
    end
    rx_token = '0;
    repeat (100) @(negedge clk);
    drain();

    $display("[TB] channel mask");
    bus_write(16'd2, 8'h0B);
    applyStimulus(4'b1101);
    prev_ch = 3'd7;
    for (int n = 0; n < 4; n++) begin
      wait_word("mask", 200);
      ch = fifo_data[29:27];
      checkOutput($sformatf("mask_ch_allowed%0d", n), 32'((ch == 3'd0) || (ch == 3'd3)), 32'd1);
      checkOutput($sformatf("mask_alternate%0d", n), 32'(ch != prev_ch), 32'd1);
      prev_ch = ch;
      pop();
    end
    rx_token = '0;
    repeat (100) @(negedge clk);
    drain();
    bus_write(16'd2, 8'h0F);

    $display("[TB] gray decode disabled");
    bus_write(16'd1, 8'd3);
    pat[2] = {6'b100000, 6'b000001, 8'h5A, 6'h15};
    applyStimulus(4'b0100);
    repeat (2) @(negedge clk);
    rx_token = '0;
    wait_word("raw", 100);
    checkOutput("raw_word", fifo_data, pack(3'd2, 6'b100000, 6'b000001, 8'h5A, 6'h15));
    pop();

    // Zero lengths behave as one cycle each; the word lands DATA_BITS+6 cycles after the token.
    $display("[TB] zero phase lengths");
    bus_write(16'd1, 8'd1);
    bus_write(16'd4, 8'd0);
    bus_write(16'd5, 8'd0);
    bus_write(16'd6, 8'd0);
    smp_eff = 1;
    pat[3] = {6'b011010, 6'b111111, 8'h3C, 6'h05};
    applyStimulus(4'b1000);
    first_read = -1; read_len = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 2) rx_token = '0;
      if (rx_read[3]) begin
        if (first_read < 0) first_read = k;
        read_len++;
      end
      if (k == 31) checkOutput("zl_empty_at_store", 32'(fifo_empty), 32'd1);
      if (k == 32) checkOutput("zl_visible", 32'(fifo_empty), 32'd0);
    end
    checkOutput("zl_read_start", 32'(first_read), 32'd4);
    checkOutput("zl_read_len", 32'(read_len), 32'd1);
    checkOutput("zl_word", fifo_data, pack(3'd3, 6'd19, 6'd42, 8'h3C, 6'h05));
    pop();

    // Token held with no reads: frame k stores at t+32k+31, so six words are lost by t+336.
    $display("[TB] overflow");
    pat[0] = {12'd0, 8'h77, 6'h01};
    applyStimulus(4'b0001);
    repeat (335) @(negedge clk);
    bus_read(16'd3, rd);
    checkOutput("ovf_lost_partial", 32'(rd), 32'd6);
    checkOutput("ovf_lost_error", 32'(lost_error), 32'd1);
    repeat (9500) @(negedge clk);
    bus_read(16'd3, rd);
    checkOutput("ovf_lost_saturated", 32'(rd), 32'd255);
    bus_read(16'd7, rd);
    checkOutput("ovf_occ_low", 32'(rd), 32'd4);
    bus_read(16'd8, rd);
    checkOutput("ovf_occ_high", 32'(rd), 32'd0);
    rx_token = '0;
    repeat (60) @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("ovf_word%0d", n), fifo_data, pack(3'd0, 6'd0, 6'd0, 8'h77, 6'h01));
      pop();
    end
    checkOutput("ovf_empty", 32'(fifo_empty), 32'd1);
    pop();
    bus_read(16'd7, rd);
    checkOutput("ovf_pop_when_empty", 32'(rd), 32'd0);

    $display("[TB] reset mid-shift");
    applyStimulus(4'b0100);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 2) rx_token = '0;
    end
    checkOutput("shift_freeze_high", 32'(rx_freeze), 32'hF);
    rst = 1'b1;
    #1;
    checkOutput("async_freeze_drop", 32'(rx_freeze), 32'd0);
    checkOutput("async_read_drop", 32'(rx_read), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    smp_eff = 3;
    repeat (40) @(negedge clk);
    checkOutput("rst_no_stray_word", 32'(fifo_empty), 32'd1);
    bus_read(16'd4, rd);
    checkOutput("rst2_tw_len", 32'(rd), 32'd2);
    bus_read(16'd3, rd);
    checkOutput("rst2_lost_cnt", 32'(rd), 32'd0);
    checkOutput("rst2_lost_error", 32'(lost_error), 32'd0);
    bus_write(16'd1, 8'd1);
    applyStimulus(4'b1010);
    repeat (2) @(negedge clk);
    rx_token = '0;
    wait_word("prio", 200);
    checkOutput("prio_ch", 32'(fifo_data[29:27]), 32'd1);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
